// File: rtl/muldiv_sequencer_if.sv
// Execute-stage request/result handshake plus the borrowed 32-bit ALU port.
// The slave side is the sequencer; the master side is the execute stage and the ALU.
interface muldiv_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        ready;
    logic        abort;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ack;
    logic [3:0]  alu_operation;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_carry;

    modport master (
        output start, op, src_a, src_b, abort, result_ack, alu_result, alu_carry,
        input  ready, result, result_valid, alu_operation, alu_a, alu_b
    );

    modport slave (
        input  start, op, src_a, src_b, abort, result_ack, alu_result, alu_carry,
        output ready, result, result_valid, alu_operation, alu_a, alu_b
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Unsigned MUL/MULHU/DIVU/REMU sequencer driving one external 32-bit ALU per iteration.
// Latency: 32 CALC cycles after acceptance (1 cycle for fast divide-by-zero).
// Backpressure: ready only in IDLE; result held in DONE until result_ack.
module muldiv_sequencer #(
    parameter bit DIV0_FAST = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    muldiv_sequencer_if.slave  bus
);
    // Shared ALU opcode encoding used across the core.
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nx;
    logic [1:0]  op_q;
    logic [31:0] operand;
    logic [31:0] acc_hi;    // multiply high half / divide remainder
    logic [31:0] acc_lo;    // multiply low half / divide quotient
    logic [4:0]  count;
    logic [31:0] result_q;

    logic [31:0] hi_nx, lo_nx, shifted;
    logic        div0_hit;

    assign div0_hit         = DIV0_FAST && bus.op[1] && (bus.src_b == 32'd0);
    assign shifted          = {acc_hi[30:0], acc_lo[31]};
    assign bus.ready        = (state == IDLE);
    assign bus.result_valid = (state == DONE);
    assign bus.result       = result_q;

    always_comb begin
        state_nx          = state;
        bus.alu_operation = ALU_ADD;
        bus.alu_a         = 32'd0;
        bus.alu_b         = 32'd0;
        hi_nx             = acc_hi;
        lo_nx             = acc_lo;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_nx = div0_hit ? DONE : CALC;
            end
            CALC: begin
                if (op_q[1]) begin
                    bus.alu_operation = ALU_SUB;
                    bus.alu_a         = shifted;
                    bus.alu_b         = operand;
                    // A set bit_out means the 33-bit partial remainder exceeds any divisor.
                    if (acc_hi[31] || !bus.alu_carry) begin
                        hi_nx = bus.alu_result;
                        lo_nx = {acc_lo[30:0], 1'b1};
                    end else begin
                        hi_nx = shifted;
                        lo_nx = {acc_lo[30:0], 1'b0};
                    end
                end else begin
                    bus.alu_operation = ALU_ADD;
                    bus.alu_a         = acc_hi;
                    bus.alu_b         = acc_lo[0] ? operand : 32'd0;
                    {hi_nx, lo_nx}    = {bus.alu_carry, bus.alu_result, acc_lo[31:1]};
                end
                if (count == 5'd31)
                    state_nx = DONE;
            end
            DONE: begin
                if (bus.result_ack)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (bus.abort)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= 2'd0;
            operand  <= 32'd0;
            acc_hi   <= 32'd0;
            acc_lo   <= 32'd0;
            count    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state <= state_nx;
            if (bus.abort) begin
                count    <= 5'd0;
                result_q <= 32'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            // operand is the multiplicand for multiply, the divisor for divide.
                            op_q    <= bus.op;
                            operand <= bus.op[1] ? bus.src_b : bus.src_a;
                            acc_hi  <= 32'd0;
                            acc_lo  <= bus.op[1] ? bus.src_a : bus.src_b;
                            count   <= 5'd0;
                            if (div0_hit)
                                result_q <= bus.op[0] ? bus.src_a : 32'hFFFF_FFFF;
                        end
                    end
                    CALC: begin
                        acc_hi <= hi_nx;
                        acc_lo <= lo_nx;
                        count  <= count + 5'd1;
                        if (count == 5'd31)
                            result_q <= op_q[0] ? hi_nx : lo_nx;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
